toy_bus_periph_node_ost: RTL and testbench

- Parametrised ToyBus-to-peripheral endpoint node; the next generation of the single-outstanding peripheral node.
- Forwards ToyBus requests to one peripheral port and supports up to OST_DEPTH outstanding reads. Each requester src_id is held in an in-order tag FIFO.
- Peripheral read data returns through a 2-entry registered skid buffer to the bus ack channel, with tgt_id taken from the tag.
- Sits between the bus crossbar target port and a simple in-order peripheral such as a timer, UART or debug register file.

---
 rtl/toy_bus_periph_node_ost.sv | 196 +++++++++++++++++++
 tb/tb_toy_bus_periph_node_ost.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_bus_periph_node_ost.sv
// ToyBus-to-peripheral endpoint node with multiple outstanding reads.
// Requests go through to the peripheral combinationally, gated by read credit.
// Each accepted read records its requester id in an in-order tag FIFO. Peripheral
// read data is paired with the oldest tag and returned through a 2-entry skid
// buffer onto the bus ack channel. Writes are posted and never acknowledged.
module toy_bus_periph_node_ost #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int OST_DEPTH = 4,
    parameter int NODE_ID   = 0
) (
    input  logic                             clk,
    input  logic                             rst,

    // bus request channel (from crossbar target port)
    input  logic                             in_req_vld,
    output logic                             in_req_rdy,
    input  logic [ADDR_W-1:0]                in_req_addr,
    input  logic [DATA_W/8-1:0]              in_req_strb,
    input  logic [DATA_W-1:0]                in_req_data,
    input  logic                             in_req_opcode,
    input  logic [ID_W-1:0]                  in_req_src_id,
    input  logic [ID_W-1:0]                  in_req_tgt_id,

    // bus ack channel (read responses back to the requester)
    output logic                             in_ack_vld,
    input  logic                             in_ack_rdy,
    output logic                             in_ack_opcode,
    output logic [DATA_W-1:0]                in_ack_data,
    output logic [ID_W-1:0]                  in_ack_src_id,
    output logic [ID_W-1:0]                  in_ack_tgt_id,

    // peripheral request channel
    output logic                             out_req_vld,
    input  logic                             out_req_rdy,
    output logic [ADDR_W-1:0]                out_req_addr,
    output logic [DATA_W-1:0]                out_req_data,
    output logic [DATA_W/8-1:0]              out_req_strb,
    output logic                             out_req_opcode,

    // peripheral read data channel
    input  logic                             out_ack_vld,
    output logic                             out_ack_rdy,
    input  logic [DATA_W-1:0]                out_ack_data,

    // status
    output logic [$clog2(OST_DEPTH+1)-1:0]   rd_ost_cnt,
    output logic                             err_orphan
);

    localparam int PW = $clog2(OST_DEPTH);
    localparam int CW = $clog2(OST_DEPTH+1);

    // ------------------------------------------------------------------
    // Tag FIFO state: pointers carry one extra wrap bit so that full and
    // empty can be told apart when the index bits match.
    // ------------------------------------------------------------------
    logic [ID_W-1:0] tag_mem [OST_DEPTH];
    logic [PW:0]     tag_wr_ptr;
    logic [PW:0]     tag_rd_ptr;
    logic [PW:0]     tag_occ;
    logic            tag_full;
    logic            tag_empty;
    logic [ID_W-1:0] tag_head;
    logic            tag_push;
    logic            tag_pop;

    // ------------------------------------------------------------------
    // Skid buffer state: two entries of {tag, data}, in order.
    // ------------------------------------------------------------------
    logic [ID_W-1:0]   skid_tag  [2];
    logic [DATA_W-1:0] skid_data [2];
    logic              skid_wr_ptr;
    logic              skid_rd_ptr;
    logic [1:0]        skid_cnt;
    logic              skid_push;
    logic              skid_pop;

    // Handshake and credit terms
    logic credit_ok;
    logic rd_accept;
    logic rsp_hs;
    logic orphan_hs;

    // The target id on the request is not needed: this node is the target.
    logic unused_tgt_id;
    assign unused_tgt_id = ^in_req_tgt_id;

    // Tag FIFO status derived from the wrap-bit pointers
    assign tag_occ   = tag_wr_ptr - tag_rd_ptr;
    assign tag_empty = (tag_wr_ptr == tag_rd_ptr);
    assign tag_full  = (tag_wr_ptr[PW] != tag_rd_ptr[PW]) &&
                       (tag_wr_ptr[PW-1:0] == tag_rd_ptr[PW-1:0]);
    assign tag_head  = tag_mem[tag_rd_ptr[PW-1:0]];
    assign rd_ost_cnt = CW'(tag_occ);

    // Request path: writes always have credit; reads need a free tag slot.
    // A pop in the same cycle does not free a slot early (no bypass).
    assign credit_ok      = in_req_opcode | ~tag_full;
    assign out_req_vld    = in_req_vld & credit_ok;
    assign in_req_rdy     = out_req_rdy & credit_ok;
    assign out_req_addr   = in_req_addr;
    assign out_req_data   = in_req_data;
    assign out_req_strb   = in_req_strb;
    assign out_req_opcode = in_req_opcode;

    assign rd_accept = in_req_vld & in_req_rdy & ~in_req_opcode;
    assign tag_push  = rd_accept;

    // Response path: accept peripheral data whenever the skid buffer has room.
    // With no tag outstanding the data has no owner and is dropped as an orphan.
    assign out_ack_rdy = (skid_cnt != 2'd2);
    assign rsp_hs      = out_ack_vld & out_ack_rdy;
    assign tag_pop     = rsp_hs & ~tag_empty;
    assign orphan_hs   = rsp_hs & tag_empty;
    assign skid_push   = tag_pop;
    assign skid_pop    = in_ack_vld & in_ack_rdy;

    // Ack channel presents the skid buffer head
    assign in_ack_vld    = (skid_cnt != 2'd0);
    assign in_ack_opcode = 1'b0;
    assign in_ack_data   = skid_data[skid_rd_ptr];
    assign in_ack_tgt_id = skid_tag[skid_rd_ptr];
    assign in_ack_src_id = ID_W'(NODE_ID);

    // Tag FIFO storage: write the requester id at the write pointer on each read accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OST_DEPTH; i++) begin
                tag_mem[i] <= '0;
            end
        end else if (tag_push) begin
            tag_mem[tag_wr_ptr[PW-1:0]] <= in_req_src_id;
        end
    end

    // Tag FIFO pointers: advance on push and pop independently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
        end else begin
            if (tag_push) begin
                tag_wr_ptr <= tag_wr_ptr + 1'b1;
            end
            if (tag_pop) begin
                tag_rd_ptr <= tag_rd_ptr + 1'b1;
            end
        end
    end

    // Skid buffer storage: capture {tag, data} for each tagged response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                skid_tag[i]  <= '0;
                skid_data[i] <= '0;
            end
        end else if (skid_push) begin
            skid_tag[skid_wr_ptr]  <= tag_head;
            skid_data[skid_wr_ptr] <= out_ack_data;
        end
    end

    // Skid buffer pointers and occupancy; the head only moves on an ack handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_wr_ptr <= 1'b0;
            skid_rd_ptr <= 1'b0;
            skid_cnt    <= 2'd0;
        end else begin
            if (skid_push) begin
                skid_wr_ptr <= ~skid_wr_ptr;
            end
            if (skid_pop) begin
                skid_rd_ptr <= ~skid_rd_ptr;
            end
            case ({skid_push, skid_pop})
                2'b10:   skid_cnt <= skid_cnt + 2'd1;
                2'b01:   skid_cnt <= skid_cnt - 2'd1;
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

    // Sticky orphan flag: set by any response that arrives with no tag outstanding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_orphan <= 1'b0;
        end else if (orphan_hs) begin
            err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_toy_bus_periph_node_ost.sv
// Directed testbench for toy_bus_periph_node_ost with default parameters.
module tb_toy_bus_periph_node_ost;

    logic        clk;
    logic        rst;
    logic        in_req_vld;
    logic        in_req_rdy;
    logic [31:0] in_req_addr;
    logic [3:0]  in_req_strb;
    logic [31:0] in_req_data;
    logic        in_req_opcode;
    logic [3:0]  in_req_src_id;
    logic [3:0]  in_req_tgt_id;
    logic        in_ack_vld;
    logic        in_ack_rdy;
    logic        in_ack_opcode;
    logic [31:0] in_ack_data;
    logic [3:0]  in_ack_src_id;
    logic [3:0]  in_ack_tgt_id;
    logic        out_req_vld;
    logic        out_req_rdy;
    logic [31:0] out_req_addr;
    logic [31:0] out_req_data;
    logic [3:0]  out_req_strb;
    logic        out_req_opcode;
    logic        out_ack_vld;
    logic        out_ack_rdy;
    logic [31:0] out_ack_data;
    logic [2:0]  rd_ost_cnt;
    logic        err_orphan;

    int checks = 0;
    int errors = 0;

    toy_bus_periph_node_ost dut (
        .clk            (clk),
        .rst            (rst),
        .in_req_vld     (in_req_vld),
        .in_req_rdy     (in_req_rdy),
        .in_req_addr    (in_req_addr),
        .in_req_strb    (in_req_strb),
        .in_req_data    (in_req_data),
        .in_req_opcode  (in_req_opcode),
        .in_req_src_id  (in_req_src_id),
        .in_req_tgt_id  (in_req_tgt_id),
        .in_ack_vld     (in_ack_vld),
        .in_ack_rdy     (in_ack_rdy),
        .in_ack_opcode  (in_ack_opcode),
        .in_ack_data    (in_ack_data),
        .in_ack_src_id  (in_ack_src_id),
        .in_ack_tgt_id  (in_ack_tgt_id),
        .out_req_vld    (out_req_vld),
        .out_req_rdy    (out_req_rdy),
        .out_req_addr   (out_req_addr),
        .out_req_data   (out_req_data),
        .out_req_strb   (out_req_strb),
        .out_req_opcode (out_req_opcode),
        .out_ack_vld    (out_ack_vld),
        .out_ack_rdy    (out_ack_rdy),
        .out_ack_data   (out_ack_data),
        .rd_ost_cnt     (rd_ost_cnt),
        .err_orphan     (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; land 2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drive one bus request
    task automatic applyStimulus(input logic vld, input logic op, input logic [3:0] src,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb);
        in_req_vld    = vld;
        in_req_opcode = op;
        in_req_src_id = src;
        in_req_addr   = addr;
        in_req_data   = data;
        in_req_strb   = strb;
    endtask

    // Compare one observed value with its expected value
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bound the whole run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        in_ack_rdy    = 1'b1;
        out_req_rdy   = 1'b1;
        out_ack_vld   = 1'b0;
        out_ack_data  = 32'h0;
        in_req_tgt_id = 4'h0;
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 4'h0);

        // Reset for 3 cycles
        repeat (3) tick();
        $display("[TB] reset state");
        checkOutput("rst_ack_vld",  in_ack_vld,    0);
        checkOutput("rst_ack_data", in_ack_data,   0);
        checkOutput("rst_ack_tgt",  in_ack_tgt_id, 0);
        checkOutput("rst_ost_cnt",  rd_ost_cnt,    0);
        checkOutput("rst_orphan",   err_orphan,    0);
        checkOutput("rst_out_rdy",  out_ack_rdy,   1);
        rst = 1'b0;
        tick();

        // Single read from src 5
        $display("[TB] single read");
        applyStimulus(1'b1, 1'b0, 4'd5, 32'h100, 32'h0, 4'hF);
        #1;
        checkOutput("rd1_in_rdy",   in_req_rdy,   1);
        checkOutput("rd1_out_vld",  out_req_vld,  1);
        checkOutput("rd1_out_addr", out_req_addr, 32'h100);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0);
        checkOutput("rd1_cnt1", rd_ost_cnt, 1);
        tick();
        checkOutput("rd1_no_ack", in_ack_vld, 0);
        out_ack_vld  = 1'b1;
        out_ack_data = 32'hDEADBEEF;
        #1;
        checkOutput("rd1_out_ack_rdy", out_ack_rdy, 1);
        tick();
        out_ack_vld = 1'b0;
        checkOutput("rd1_ack_vld",  in_ack_vld,    1);
        checkOutput("rd1_ack_tgt",  in_ack_tgt_id, 5);
        checkOutput("rd1_ack_src",  in_ack_src_id, 0);
        checkOutput("rd1_ack_op",   in_ack_opcode, 0);
        checkOutput("rd1_ack_data", in_ack_data,   32'hDEADBEEF);
        checkOutput("rd1_cnt0",     rd_ost_cnt,    0);
        tick();
        checkOutput("rd1_ack_done", in_ack_vld, 0);

        // Posted write
        $display("[TB] posted write");
        applyStimulus(1'b1, 1'b1, 4'd2, 32'h200, 32'h1234, 4'h3);
        #1;
        checkOutput("wr_out_vld",  out_req_vld,    1);
        checkOutput("wr_in_rdy",   in_req_rdy,     1);
        checkOutput("wr_out_data", out_req_data,   32'h1234);
        checkOutput("wr_out_strb", out_req_strb,   4'h3);
        checkOutput("wr_out_op",   out_req_opcode, 1);
        checkOutput("wr_out_addr", out_req_addr,   32'h200);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0);
        checkOutput("wr_cnt",     rd_ost_cnt, 0);
        checkOutput("wr_no_ack1", in_ack_vld, 0);
        tick();
        checkOutput("wr_no_ack2", in_ack_vld, 0);

        // Credit limit: four reads fill the tag FIFO
        $display("[TB] credit limit");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b0, 4'(i), 32'h300, 32'h0, 4'hF);
            tick();
        end
        checkOutput("cr_cnt4", rd_ost_cnt, 4);
        applyStimulus(1'b1, 1'b0, 4'd5, 32'h300, 32'h0, 4'hF);
        #1;
        checkOutput("cr_rd_blocked", in_req_rdy,  0);
        checkOutput("cr_rd_no_vld",  out_req_vld, 0);
        applyStimulus(1'b1, 1'b1, 4'd5, 32'h304, 32'h77, 4'hF);
        #1;
        checkOutput("cr_wr_rdy", in_req_rdy,  1);
        checkOutput("cr_wr_vld", out_req_vld, 1);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0);
        checkOutput("cr_cnt_after_wr", rd_ost_cnt, 4);
        out_ack_vld  = 1'b1;
        out_ack_data = 32'hA1;
        tick();
        out_ack_vld = 1'b0;
        checkOutput("cr_cnt3",     rd_ost_cnt,    3);
        checkOutput("cr_ack1_tgt", in_ack_tgt_id, 1);
        #1;
        checkOutput("cr_rd_rdy_again", in_req_rdy, 1);
        out_ack_vld = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            out_ack_data = 32'hA0 + 32'(i);
            tick();
            checkOutput("cr_drain_vld",  in_ack_vld,    1);
            checkOutput("cr_drain_tgt",  in_ack_tgt_id, 64'(i));
            checkOutput("cr_drain_data", in_ack_data,   64'h00A0 + 64'(i));
        end
        out_ack_vld = 1'b0;
        tick();
        checkOutput("cr_drained_vld", in_ack_vld, 0);
        checkOutput("cr_drained_cnt", rd_ost_cnt, 0);

        // Ordering with ack backpressure
        $display("[TB] ordering with backpressure");
        for (int i = 7; i <= 10; i++) begin
            applyStimulus(1'b1, 1'b0, 4'(i), 32'h400, 32'h0, 4'hF);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0);
        in_ack_rdy   = 1'b0;
        out_ack_vld  = 1'b1;
        out_ack_data = 32'hB7;
        #1;
        checkOutput("bp_rdy_c1", out_ack_rdy, 1);
        tick();
        out_ack_data = 32'hB8;
        #1;
        checkOutput("bp_rdy_c2", out_ack_rdy, 1);
        tick();
        checkOutput("bp_head_tgt",  in_ack_tgt_id, 7);
        checkOutput("bp_head_data", in_ack_data,   32'hB7);
        out_ack_data = 32'hB9;
        repeat (4) begin
            #1;
            checkOutput("bp_rdy_low", out_ack_rdy, 0);
            tick();
        end
        checkOutput("bp_hold_vld",  in_ack_vld,    1);
        checkOutput("bp_hold_tgt",  in_ack_tgt_id, 7);
        checkOutput("bp_hold_data", in_ack_data,   32'hB7);
        checkOutput("bp_hold_cnt",  rd_ost_cnt,    2);
        in_ack_rdy = 1'b1;
        tick();
        checkOutput("bp_o8_tgt",  in_ack_tgt_id, 8);
        checkOutput("bp_o8_data", in_ack_data,   32'hB8);
        tick();
        out_ack_data = 32'hBA;
        checkOutput("bp_o9_tgt",  in_ack_tgt_id, 9);
        checkOutput("bp_o9_data", in_ack_data,   32'hB9);
        checkOutput("bp_o9_cnt",  rd_ost_cnt,    1);
        tick();
        out_ack_vld = 1'b0;
        checkOutput("bp_o10_vld",  in_ack_vld,    1);
        checkOutput("bp_o10_tgt",  in_ack_tgt_id, 10);
        checkOutput("bp_o10_data", in_ack_data,   32'hBA);
        checkOutput("bp_o10_cnt",  rd_ost_cnt,    0);
        tick();
        checkOutput("bp_empty", in_ack_vld, 0);
        checkOutput("bp_no_orphan", err_orphan, 0);

        // Orphan response
        $display("[TB] orphan response");
        out_ack_vld  = 1'b1;
        out_ack_data = 32'h55;
        #1;
        checkOutput("orph_out_rdy", out_ack_rdy, 1);
        tick();
        out_ack_vld = 1'b0;
        checkOutput("orph_set",    err_orphan, 1);
        checkOutput("orph_no_ack", in_ack_vld, 0);
        checkOutput("orph_cnt",    rd_ost_cnt, 0);
        repeat (2) tick();
        checkOutput("orph_held",    err_orphan, 1);
        checkOutput("orph_no_ack2", in_ack_vld, 0);

        // Reset mid-operation
        $display("[TB] reset mid-operation");
        in_ack_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b0, 4'(i), 32'h500, 32'h0, 4'hF);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0);
        out_ack_vld  = 1'b1;
        out_ack_data = 32'hC1;
        tick();
        out_ack_vld = 1'b0;
        checkOutput("mr_pre_vld", in_ack_vld, 1);
        checkOutput("mr_pre_cnt", rd_ost_cnt, 3);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("mr_ack_vld",  in_ack_vld,    0);
        checkOutput("mr_cnt",      rd_ost_cnt,    0);
        checkOutput("mr_orphan",   err_orphan,    0);
        checkOutput("mr_ack_data", in_ack_data,   0);
        checkOutput("mr_ack_tgt",  in_ack_tgt_id, 0);
        tick();
        rst        = 1'b0;
        in_ack_rdy = 1'b1;
        tick();
        out_ack_vld  = 1'b1;
        out_ack_data = 32'hC2;
        tick();
        out_ack_vld = 1'b0;
        checkOutput("mr_late_orphan", err_orphan, 1);
        checkOutput("mr_late_no_ack", in_ack_vld, 0);
        checkOutput("mr_late_cnt",    rd_ost_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
